ssd_scan_controller: RTL and testbench
======================================

# ssd_scan_controller

Sequencing controller for the 4-digit common-anode seven-segment display. It owns the digit scan, inserts a ghost-suppression blanking gap before each digit, and double-buffers the four 3-bit digit values. Writers update a shadow bank through a valid/ready handshake, and the shadow bank is committed to the displayed bank only at a frame boundary, so a display frame never shows a mix of old and new digits. It sits between the switch/user-input logic and the board anode/cathode pins.

## Interface
- CLK_HZ, 50000000, input clock frequency
- SCAN_HZ, 400, digit-slot rate; frame rate = SCAN_HZ/4
- BLANK_CYCLES, 500, cycles per slot with all anodes off; must satisfy 1 ≤ BLANK_CYCLES < SLOT_CYCLES
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_sel  in  2  target digit, 0 = leftmost
- wr_data  in  3  digit value 0..7
- blank_mask  in  4  bit i = 1 suppresses digit i
- frame_start  out  1  one-cycle pulse at the start of slot 0
- digit_sel  out  2  slot currently being scanned
- anode  out  4  active-low digit enables; bit 3 = leftmost digit
- cathode  out  7  active-low segments a..g, MSB = a

## Operation
- SLOT_CYCLES = CLK_HZ/SCAN_HZ, using integer division. A slot counter runs 0..SLOT_CYCLES-1, and digit_sel increments from 3 back to 0 when the slot counter wraps.
- FSM per slot, with states BLANK and DRIVE:
  - BLANK: slot counter < BLANK_CYCLES. anode = 1111, cathode = 1111111.
  - DRIVE: slot counter ≥ BLANK_CYCLES. anode = one-cold (slot 0 = 0111, 1 = 1011, 2 = 1101, 3 = 1110). cathode = decode(active[digit_sel]).
  - BLANK → DRIVE when the slot counter reaches BLANK_CYCLES. DRIVE → BLANK when the slot counter wraps.
- blank_mask is sampled on the first BLANK cycle of each slot and held for that slot. If the sampled bit is set, DRIVE keeps anode = 1111 and cathode = 1111111. The slot still consumes its full time.
- Decode (cathode): 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111.
- Writes:
  - An accepted write stores shadow[wr_sel] <= wr_data and sets dirty.
  - Several writes per frame are allowed; the last write to a given digit wins.
- Commit:
  - Occurs on the last cycle of slot 3 (slot counter = SLOT_CYCLES-1, digit_sel = 3), and only if dirty is set.
  - Effect: active <= shadow, dirty <= 0.
  - wr_ready = 0 on that cycle, whether or not dirty is set. wr_ready = 1 on all other cycles.
- A write presented during the commit cycle stalls and is accepted on the next cycle (the first cycle of slot 0). It is displayed in the following frame.
- Reset (reset = 0 on a rising clk), at any point including mid-slot or on the commit cycle:
  - active = 0, shadow = 0, dirty = 0, digit_sel = 0, slot counter = 0, state = BLANK.
  - anode = 1111, cathode = 1111111, frame_start = 0, wr_ready = 0.
  - A write in progress is dropped.

## Timing
- All outputs except wr_ready are registered. wr_ready is combinational from the slot counter and digit_sel only; it has no path from wr_valid.
- First cycle after reset release: slot counter = 0, digit_sel = 0, state = BLANK, frame_start = 1, wr_ready = 1.
- frame_start is high for exactly one cycle per frame, on the first BLANK cycle of slot 0.
- Anode changes occur only at BLANK boundaries; two anodes are never low in the same cycle.
- Write-to-display latency: the accepted value first appears on cathode in the first DRIVE phase of its digit after the next commit.
- Frame period = 4 × SLOT_CYCLES cycles (100 Hz at the defaults).

## Structure
- Shared package holds:
  - the 3-bit digit type;
  - the 7-bit segment type;
  - the eight segment-pattern constants plus the all-off constant 1111111;
  - the anode one-cold constants and ANODE_OFF = 1111;
  - the FSM state enum {BLANK, DRIVE}.
- One combinational sub-module, ssd_segment_decoder (digit → cathode), shared with other display blocks.
- Slot counter, FSM, shadow/active banks and commit logic live in the top.

## Test plan
All scenarios use CLK_HZ = 1000, SCAN_HZ = 100, BLANK_CYCLES = 2, so SLOT_CYCLES = 10 and the frame is 40 cycles.

- **Reset and idle.** Hold reset low for 3 cycles, then release. anode/cathode = 1111/1111111 during reset. After release, frame_start pulses every 40 cycles. Anode sequence per slot is 2 cycles of 1111 then 8 cycles of one-cold, in the order 0111, 1011, 1101, 1110. cathode = 0000001 in every DRIVE phase.
- **Commit boundary.** Mid-frame, write sel=2, data=5. Slot 2 still shows 0000001 in the current frame. In the next frame, slot 2 shows 0100100.
- **Commit-cycle stall.** Assert wr_valid (sel=0, data=7) on cycle 39 of a frame. wr_ready = 0 on cycle 39 and 1 on cycle 40, where the write is accepted. 0001111 appears in slot 0 of the frame after next.
- **Last write wins.** In one frame write sel=1 data=3, then sel=1 data=6. Only 0100000 appears in slot 1 after the commit, and 0000110 never appears.
- **blank_mask.** Set blank_mask = 0100 mid-slot 1. Slot 1 remains lit for the rest of that slot. Slot 2 keeps anode = 1111 for the full slot. Timing of slots 3 and 0 is unchanged.
- **Reset mid-operation.** Pull reset low during DRIVE of slot 2 with dirty set. Outputs are all-off on the next edge. After release, the display shows 0 in all four slots, and the pending write is not committed.

Source files
------------

// File: rtl/ssd_scan_controller_pkg.sv
// Shared types and constants for the 4-digit common-anode seven-segment display blocks.
// Segment patterns are active-low a..g with a in the MSB.
package ssd_scan_controller_pkg;

    typedef logic [2:0] digit_t;
    typedef logic [6:0] seg_t;

    typedef enum logic {BLANK, DRIVE} state_e;

    localparam seg_t SEG_0   = 7'b0000001;
    localparam seg_t SEG_1   = 7'b1001111;
    localparam seg_t SEG_2   = 7'b0010010;
    localparam seg_t SEG_3   = 7'b0000110;
    localparam seg_t SEG_4   = 7'b1001100;
    localparam seg_t SEG_5   = 7'b0100100;
    localparam seg_t SEG_6   = 7'b0100000;
    localparam seg_t SEG_7   = 7'b0001111;
    localparam seg_t SEG_OFF = 7'b1111111;

    localparam logic [3:0] ANODE_SLOT0 = 4'b0111;
    localparam logic [3:0] ANODE_SLOT1 = 4'b1011;
    localparam logic [3:0] ANODE_SLOT2 = 4'b1101;
    localparam logic [3:0] ANODE_SLOT3 = 4'b1110;
    localparam logic [3:0] ANODE_OFF   = 4'b1111;

    // Slot 0 is the leftmost digit, which sits on anode bit 3.
    function automatic logic [3:0] anode_for(input logic [1:0] slot);
        logic [3:0] a;
        a = ANODE_OFF;
        unique case (slot)
            2'd0: a = ANODE_SLOT0;
            2'd1: a = ANODE_SLOT1;
            2'd2: a = ANODE_SLOT2;
            2'd3: a = ANODE_SLOT3;
            default: a = ANODE_OFF;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/ssd_scan_controller_if.sv
// Digit write bus: the writer (master) presents sel/data with valid, the controller returns ready.
interface ssd_scan_controller_if;
    import ssd_scan_controller_pkg::*;

    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_sel;
    digit_t     wr_data;

    modport master (output wr_valid, output wr_sel, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_sel, input wr_data, output wr_ready);

endinterface

// File: rtl/ssd_segment_decoder.sv
// Combinational digit (0..7) to active-low seven-segment pattern decoder.
module ssd_segment_decoder
    import ssd_scan_controller_pkg::*;
(
    input  digit_t i_digit,
    output seg_t   o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        unique case (i_digit)
            3'd0: o_seg = SEG_0;
            3'd1: o_seg = SEG_1;
            3'd2: o_seg = SEG_2;
            3'd3: o_seg = SEG_3;
            3'd4: o_seg = SEG_4;
            3'd5: o_seg = SEG_5;
            3'd6: o_seg = SEG_6;
            3'd7: o_seg = SEG_7;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/ssd_scan_controller.sv
// Four-digit scan controller with per-slot blanking gap and a shadow/active digit bank
// that is committed only at the frame boundary.
module ssd_scan_controller
    import ssd_scan_controller_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned SCAN_HZ      = 400,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    ssd_scan_controller_if.slave wr_bus,
    input  logic [3:0]           i_blank_mask,
    output logic                 o_frame_start,
    output logic [1:0]           o_digit_sel,
    output logic [3:0]           o_anode,
    output seg_t                 o_cathode
);

    localparam int unsigned SlotCycles = CLK_HZ / SCAN_HZ;
    localparam int unsigned CntW       = (SlotCycles > 1) ? $clog2(SlotCycles) : 1;
    localparam logic [CntW-1:0] CntLast  = CntW'(SlotCycles - 1);
    localparam logic [CntW-1:0] CntBlank = CntW'(BLANK_CYCLES);

    logic            r_run;
    logic [CntW-1:0] r_slot_cnt;
    logic [CntW-1:0] w_slot_cnt_d;
    logic [1:0]      r_digit_sel;
    logic [1:0]      w_digit_sel_d;
    state_e          r_state;
    state_e          w_state_d;
    logic            r_mask;
    logic            w_mask;
    digit_t          r_shadow [4];
    digit_t          r_active [4];
    logic            r_dirty;
    logic            w_commit_cycle;
    logic            w_wr_fire;
    seg_t            w_seg;
    logic [3:0]      w_anode_d;
    seg_t            w_cathode_d;
    logic [3:0]      r_anode;
    seg_t            r_cathode;
    logic            r_frame_start;

    // r_run holds the counters still on the release edge so the first live cycle is slot 0, count 0.
    assign w_commit_cycle  = r_run && (r_slot_cnt == CntLast) && (r_digit_sel == 2'd3);
    assign wr_bus.wr_ready = r_run && !w_commit_cycle;
    assign w_wr_fire       = wr_bus.wr_valid && wr_bus.wr_ready;

    always_comb begin
        w_slot_cnt_d  = r_slot_cnt;
        w_digit_sel_d = r_digit_sel;
        if (r_run) begin
            if (r_slot_cnt == CntLast) begin
                w_slot_cnt_d  = '0;
                w_digit_sel_d = r_digit_sel + 2'd1;
            end else begin
                w_slot_cnt_d = r_slot_cnt + CntW'(1);
            end
        end
    end

    // The mask bit is captured during the first blanking cycle and held for the rest of the slot.
    assign w_mask = (r_slot_cnt == '0) ? i_blank_mask[r_digit_sel] : r_mask;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= BLANK;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            BLANK:   if (w_slot_cnt_d == CntBlank) w_state_d = DRIVE;
            DRIVE:   if (w_slot_cnt_d == '0)       w_state_d = BLANK;
            default: w_state_d = BLANK;
        endcase
    end

    ssd_segment_decoder u_decoder (
        .i_digit (r_active[w_digit_sel_d]),
        .o_seg   (w_seg)
    );

    // Outputs are decoded from the next state so the registered pins line up with the counters.
    always_comb begin
        w_anode_d   = ANODE_OFF;
        w_cathode_d = SEG_OFF;
        if (w_state_d == DRIVE && !w_mask) begin
            w_anode_d   = anode_for(w_digit_sel_d);
            w_cathode_d = w_seg;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_run         <= 1'b0;
            r_slot_cnt    <= '0;
            r_digit_sel   <= 2'd0;
            r_mask        <= 1'b0;
            r_anode       <= ANODE_OFF;
            r_cathode     <= SEG_OFF;
            r_frame_start <= 1'b0;
        end else begin
            r_run         <= 1'b1;
            r_slot_cnt    <= w_slot_cnt_d;
            r_digit_sel   <= w_digit_sel_d;
            r_mask        <= w_mask;
            r_anode       <= w_anode_d;
            r_cathode     <= w_cathode_d;
            r_frame_start <= (w_slot_cnt_d == '0) && (w_digit_sel_d == 2'd0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
            r_dirty <= 1'b0;
        end else if (w_commit_cycle) begin
            if (r_dirty) begin
                r_active <= r_shadow;
                r_dirty  <= 1'b0;
            end
        end else if (w_wr_fire) begin
            r_shadow[wr_bus.wr_sel] <= wr_bus.wr_data;
            r_dirty                 <= 1'b1;
        end
    end

    assign o_frame_start = r_frame_start;
    assign o_digit_sel   = r_digit_sel;
    assign o_anode       = r_anode;
    assign o_cathode     = r_cathode;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Self-checking bench for ssd_scan_controller against a frame-position reference model.
module tb_ssd_scan_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] blank_mask = 4'b0000;
    logic       frame_start;
    logic [1:0] digit_sel;
    logic [3:0] anode;
    logic [6:0] cathode;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: m_t counts cycles since reset release; everything else follows from it.
    int         m_t = 0;
    bit         m_run = 1'b0;
    bit         m_dirty = 1'b0;
    bit         m_mask = 1'b0;
    logic [2:0] m_shadow [4];
    logic [2:0] m_active [4];

    ssd_scan_controller_if bus ();

    ssd_scan_controller #(
        .CLK_HZ       (1000),
        .SCAN_HZ      (100),
        .BLANK_CYCLES (2)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .wr_bus        (bus),
        .i_blank_mask  (blank_mask),
        .o_frame_start (frame_start),
        .o_digit_sel   (digit_sel),
        .o_anode       (anode),
        .o_cathode     (cathode)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg7(input logic [2:0] d);
        logic [6:0] t [8];
        t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111};
        return t[d];
    endfunction

    function automatic int mpos();
        return m_t % 40;
    endfunction

    // {frame_start, wr_ready, digit_sel, anode, cathode}
    function automatic logic [14:0] model_out();
        int pos, slot, cnt;
        bit drive;
        logic [3:0] an;
        logic [6:0] ca;
        if (!m_run) return {2'b00, 2'b00, 4'b1111, 7'b1111111};
        pos   = mpos();
        slot  = pos / 10;
        cnt   = pos % 10;
        drive = (cnt >= 2) && !m_mask;
        an    = drive ? (4'b1111 ^ (4'b1000 >> slot)) : 4'b1111;
        ca    = drive ? seg7(m_active[slot]) : 7'b1111111;
        return {(pos == 0), (pos != 39), 2'(slot), an, ca};
    endfunction

    function automatic logic [14:0] obs();
        return {frame_start, bus.wr_ready, digit_sel, anode, cathode};
    endfunction

    // Advance model and DUT by one clock using the inputs currently presented.
    task automatic tick();
        int pos;
        bit ready;
        pos = mpos();
        if (!rst_n) begin
            m_run   = 1'b0;
            m_t     = 0;
            m_dirty = 1'b0;
            m_mask  = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_shadow[i] = 3'd0;
                m_active[i] = 3'd0;
            end
        end else begin
            ready = m_run && (pos != 39);
            if (m_run && pos == 39) begin
                if (m_dirty) begin
                    m_active = m_shadow;
                    m_dirty  = 1'b0;
                end
            end else if (bus.wr_valid && ready) begin
                m_shadow[bus.wr_sel] = bus.wr_data;
                m_dirty              = 1'b1;
            end
            if (m_run && (pos % 10) == 0) m_mask = blank_mask[pos / 10];
            if (m_run) m_t++;
            m_run = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) begin
            tick();
            n_chk++;
            if ({anode, cathode, frame_start, bus.wr_ready} !== {4'hF, 7'h7F, 2'b00})
                $display("FAIL reset_hold got=%b_%b_%b_%b exp=1111_1111111_0_0",
                         anode, cathode, frame_start, bus.wr_ready);
            else n_pass++;
        end
        rst_n = 1'b1;
        tick();
        n_chk++;
        if ({frame_start, bus.wr_ready, digit_sel, anode} !== 8'b1100_1111)
            $display("FAIL reset_first_cycle got=%b exp=11001111",
                     {frame_start, bus.wr_ready, digit_sel, anode});
        else n_pass++;
        repeat (90) begin
            tick();
            n_chk++;
            if (obs() !== model_out())
                $display("FAIL reset_idle t=%0d got=%b exp=%b", m_t, obs(), model_out());
            else n_pass++;
        end
    endtask

    task automatic test_commit_boundary();
        int frames;
        for (int k = 0; k < 40 && mpos() != 15; k++) tick();
        bus.wr_valid = 1'b1;
        bus.wr_sel   = 2'd2;
        bus.wr_data  = 3'd5;
        tick();
        bus.wr_valid = 1'b0;
        frames = 0;
        for (int k = 0; k < 70; k++) begin
            tick();
            if (mpos() == 0) frames++;
            n_chk++;
            if (obs() !== model_out())
                $display("FAIL commit_boundary t=%0d got=%b exp=%b", m_t, obs(), model_out());
            else n_pass++;
            if (mpos() == 25) begin
                n_chk++;
                if (cathode !== (frames == 0 ? 7'b0000001 : 7'b0100100))
                    $display("FAIL commit_boundary_slot2 frame=%0d got=%b", frames, cathode);
                else n_pass++;
            end
        end
    endtask

    task automatic test_commit_stall();
        int frames;
        for (int k = 0; k < 40 && mpos() != 39; k++) tick();
        bus.wr_valid = 1'b1;
        bus.wr_sel   = 2'd0;
        bus.wr_data  = 3'd7;
        n_chk++;
        if (bus.wr_ready !== 1'b0) $display("FAIL stall_ready_c39 got=%b exp=0", bus.wr_ready);
        else n_pass++;
        tick();
        n_chk++;
        if (bus.wr_ready !== 1'b1) $display("FAIL stall_ready_c40 got=%b exp=1", bus.wr_ready);
        else n_pass++;
        tick();
        bus.wr_valid = 1'b0;
        frames = 0;
        for (int k = 0; k < 90; k++) begin
            tick();
            if (mpos() == 0) frames++;
            n_chk++;
            if (obs() !== model_out())
                $display("FAIL commit_stall t=%0d got=%b exp=%b", m_t, obs(), model_out());
            else n_pass++;
            if (mpos() == 5) begin
                n_chk++;
                if (cathode !== (frames == 0 ? 7'b0000001 : 7'b0001111))
                    $display("FAIL commit_stall_slot0 frame=%0d got=%b", frames, cathode);
                else n_pass++;
            end
        end
    endtask

    task automatic test_last_write_wins();
        int frames;
        for (int k = 0; k < 40 && mpos() != 5; k++) tick();
        bus.wr_valid = 1'b1;
        bus.wr_sel   = 2'd1;
        bus.wr_data  = 3'd3;
        tick();
        bus.wr_valid = 1'b0;
        tick();
        tick();
        bus.wr_valid = 1'b1;
        bus.wr_data  = 3'd6;
        tick();
        bus.wr_valid = 1'b0;
        frames = 0;
        for (int k = 0; k < 90; k++) begin
            tick();
            if (mpos() == 0) frames++;
            n_chk++;
            if (obs() !== model_out() || cathode === 7'b0000110)
                $display("FAIL last_write t=%0d got=%b exp=%b", m_t, obs(), model_out());
            else n_pass++;
            if (mpos() == 15) begin
                n_chk++;
                if (cathode !== (frames == 0 ? 7'b0000001 : 7'b0100000))
                    $display("FAIL last_write_slot1 frame=%0d got=%b", frames, cathode);
                else n_pass++;
            end
        end
    endtask

    task automatic test_blank_mask();
        logic [3:0] exp_an;
        for (int k = 0; k < 40 && mpos() != 15; k++) tick();
        blank_mask = 4'b0100;
        for (int k = 0; k < 45; k++) begin
            tick();
            n_chk++;
            if (obs() !== model_out())
                $display("FAIL blank_mask t=%0d got=%b exp=%b", m_t, obs(), model_out());
            else n_pass++;
            if (mpos() % 10 >= 2) begin
                exp_an = (mpos() / 10 == 0) ? 4'b0111 : (mpos() / 10 == 1) ? 4'b1011 :
                         (mpos() / 10 == 2) ? 4'b1111 : 4'b1110;
                n_chk++;
                if (anode !== exp_an)
                    $display("FAIL blank_mask_anode pos=%0d got=%b exp=%b", mpos(), anode, exp_an);
                else n_pass++;
            end
        end
        blank_mask = 4'b0000;
        for (int k = 0; k < 45; k++) begin
            tick();
            n_chk++;
            if (obs() !== model_out())
                $display("FAIL blank_mask_clear t=%0d got=%b exp=%b", m_t, obs(), model_out());
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 40 && mpos() != 10; k++) tick();
        bus.wr_valid = 1'b1;
        bus.wr_sel   = 2'd3;
        bus.wr_data  = 3'd4;
        tick();
        bus.wr_valid = 1'b0;
        for (int k = 0; k < 40 && mpos() != 22; k++) tick();
        rst_n = 1'b0;
        tick();
        n_chk++;
        if (obs() !== {2'b00, 2'b00, 4'b1111, 7'b1111111})
            $display("FAIL reset_mid_off got=%b exp=000011111111111", obs());
        else n_pass++;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 90; k++) begin
            tick();
            n_chk++;
            if (obs() !== model_out())
                $display("FAIL reset_mid t=%0d got=%b exp=%b", m_t, obs(), model_out());
            else n_pass++;
            if (mpos() % 10 == 5) begin
                n_chk++;
                if (cathode !== 7'b0000001)
                    $display("FAIL reset_mid_zero pos=%0d got=%b exp=0000001", mpos(), cathode);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            bus.wr_valid = ($urandom_range(0, 2) == 0);
            bus.wr_sel   = 2'($urandom_range(0, 3));
            bus.wr_data  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) blank_mask = 4'($urandom_range(0, 15));
            rst_n = ($urandom_range(0, 199) != 0);
            tick();
            n_chk++;
            if (obs() !== model_out())
                $display("FAIL random t=%0d got=%b exp=%b", m_t, obs(), model_out());
            else n_pass++;
        end
        rst_n        = 1'b1;
        bus.wr_valid = 1'b0;
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_sel   = 2'd0;
        bus.wr_data  = 3'd0;
        for (int i = 0; i < 4; i++) begin
            m_shadow[i] = 3'd0;
            m_active[i] = 3'd0;
        end
        test_reset();
        test_commit_boundary();
        test_commit_stall();
        test_last_write_wins();
        test_blank_mask();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
